// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit_pkg : shared types and constants for the load/store unit
// Revision: 1.0
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

  localparam int LSU_ADDR_WIDTH    = 32;
  localparam int LSU_PORT_WIDTH    = 32;
  localparam int LSU_WAY_WIDTH     = 1;
  localparam int LSU_BLOCK_WORDS   = 4;
  localparam int LSU_BYTE_OFFSET_W = 2;
  localparam int LSU_WORD_OFFSET_W = $clog2(LSU_BLOCK_WORDS);
  localparam int LSU_LINE_OFFSET_W = LSU_WORD_OFFSET_W + LSU_BYTE_OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMPARE  = 2'd1,
    ST_MISS_REQ = 2'd2,
    ST_REFILL   = 2'd3
  } ld_state_e;

  typedef struct packed {
    logic [LSU_WAY_WIDTH-1:0]  way;
    logic [LSU_ADDR_WIDTH-1:0] address;
    logic [LSU_PORT_WIDTH-1:0] data;
  } refill_write_t;

endpackage
`default_nettype wire

// File: rtl/data_cache_port1_load_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_cache_port1_load_controller : port 1 load lookup and line refill FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
module data_cache_port1_load_controller
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int PORT_WIDTH  = 32,
  parameter int WAYS_NUMBER = 2,
  parameter int BLOCK_WORDS = LSU_BLOCK_WORDS,
  localparam int WAY_W      = (WAYS_NUMBER > 1) ? $clog2(WAYS_NUMBER) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ldu_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] ldu_address_i,
  output logic                  ldu_req_ready_o,
  output logic [PORT_WIDTH-1:0] ldu_data_o,
  output logic                  ldu_valid_o,
  output logic                  cache_read_o,
  output logic [ADDR_WIDTH-1:0] cache_address_o,
  input  logic                  cache_hit_i,
  input  logic [PORT_WIDTH-1:0] cache_data_i,
  input  logic [WAY_W-1:0]      replace_way_i,
  output logic                  cache_write_o,
  output logic [WAY_W-1:0]      cache_write_way_o,
  output logic [ADDR_WIDTH-1:0] cache_write_address_o,
  output logic [PORT_WIDTH-1:0] cache_write_data_o,
  output logic                  cache_validate_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  input  logic                  mem_ack_i,
  input  logic [PORT_WIDTH-1:0] mem_data_i,
  input  logic                  mem_data_valid_i
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int LINE_W = OFF_W + LSU_BYTE_OFFSET_W;

  ld_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:LSU_BYTE_OFFSET_W] addr_q, addr_d;
  logic [WAY_W-1:0]                      way_q, way_d;
  logic [OFF_W-1:0]                      cnt_q, cnt_d;
  logic [PORT_WIDTH-1:0]                 crit_q, crit_d;
  logic [PORT_WIDTH-1:0]                 ldu_data_q, ldu_data_d;
  logic                                  ldu_valid_q, ldu_valid_d;

  logic [OFF_W-1:0] w_req_offset;
  logic             w_refill_beat;
  logic             w_last;
  logic             w_critical;

  assign w_req_offset  = addr_q[LINE_W-1:LSU_BYTE_OFFSET_W];
  assign w_refill_beat = (state_q == ST_REFILL) && mem_data_valid_i;
  assign w_last        = (cnt_q == OFF_W'(BLOCK_WORDS - 1));
  assign w_critical    = (cnt_q == w_req_offset);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (ldu_req_valid_i) state_d = ST_COMPARE;
      ST_COMPARE:  state_d = cache_hit_i ? ST_IDLE : ST_MISS_REQ;
      ST_MISS_REQ: if (mem_ack_i) state_d = ST_REFILL;
      ST_REFILL:   if (w_refill_beat && w_last) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // The critical word may be the last one, so it is forwarded directly then.
  always_comb begin
    addr_d      = addr_q;
    way_d       = way_q;
    cnt_d       = cnt_q;
    crit_d      = crit_q;
    ldu_data_d  = ldu_data_q;
    ldu_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ldu_req_valid_i) addr_d = ldu_address_i[ADDR_WIDTH-1:LSU_BYTE_OFFSET_W];
      end
      ST_COMPARE: begin
        if (cache_hit_i) begin
          ldu_data_d  = cache_data_i;
          ldu_valid_d = 1'b1;
        end else begin
          way_d = replace_way_i;
        end
      end
      ST_MISS_REQ: begin
        if (mem_ack_i) cnt_d = '0;
      end
      ST_REFILL: begin
        if (mem_data_valid_i) begin
          if (w_critical) crit_d = mem_data_i;
          if (w_last) begin
            ldu_data_d  = w_critical ? mem_data_i : crit_q;
            ldu_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + OFF_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      way_q       <= '0;
      cnt_q       <= '0;
      crit_q      <= '0;
      ldu_data_q  <= '0;
      ldu_valid_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      way_q       <= way_d;
      cnt_q       <= cnt_d;
      crit_q      <= crit_d;
      ldu_data_q  <= ldu_data_d;
      ldu_valid_q <= ldu_valid_d;
    end
  end

  always_comb begin
    ldu_req_ready_o       = (state_q == ST_IDLE);
    cache_read_o          = (state_q == ST_IDLE) && ldu_req_valid_i;
    cache_address_o       = ldu_address_i;
    mem_req_o             = (state_q == ST_MISS_REQ);
    mem_address_o         = {addr_q[ADDR_WIDTH-1:LINE_W], {LINE_W{1'b0}}};
    cache_write_o         = w_refill_beat;
    cache_write_way_o     = way_q;
    cache_write_address_o = {addr_q[ADDR_WIDTH-1:LINE_W], cnt_q, {LSU_BYTE_OFFSET_W{1'b0}}};
    cache_write_data_o    = mem_data_i;
    cache_validate_o      = w_refill_beat && w_last;
    ldu_data_o            = ldu_data_q;
    ldu_valid_o           = ldu_valid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache_port1_load_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_cache_port1_load_controller : directed bench for the port 1 load FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_data_cache_port1_load_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ldu_req_valid_i;
  logic [31:0] ldu_address_i;
  logic        ldu_req_ready_o;
  logic [31:0] ldu_data_o;
  logic        ldu_valid_o;
  logic        cache_read_o;
  logic [31:0] cache_address_o;
  logic        cache_hit_i;
  logic [31:0] cache_data_i;
  logic [0:0]  replace_way_i;
  logic        cache_write_o;
  logic [0:0]  cache_write_way_o;
  logic [31:0] cache_write_address_o;
  logic [31:0] cache_write_data_o;
  logic        cache_validate_o;
  logic        mem_req_o;
  logic [31:0] mem_address_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        mem_data_valid_i;

  int vectors = 0;
  int miscompares = 0;

  data_cache_port1_load_controller #(
    .ADDR_WIDTH(32), .PORT_WIDTH(32), .WAYS_NUMBER(2), .BLOCK_WORDS(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ldu_req_valid_i(ldu_req_valid_i), .ldu_address_i(ldu_address_i),
    .ldu_req_ready_o(ldu_req_ready_o), .ldu_data_o(ldu_data_o), .ldu_valid_o(ldu_valid_o),
    .cache_read_o(cache_read_o), .cache_address_o(cache_address_o),
    .cache_hit_i(cache_hit_i), .cache_data_i(cache_data_i), .replace_way_i(replace_way_i),
    .cache_write_o(cache_write_o), .cache_write_way_o(cache_write_way_o),
    .cache_write_address_o(cache_write_address_o), .cache_write_data_o(cache_write_data_o),
    .cache_validate_o(cache_validate_o),
    .mem_req_o(mem_req_o), .mem_address_o(mem_address_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .mem_data_valid_i(mem_data_valid_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 1'b0; ldu_req_valid_i = 1'b0; ldu_address_i = '0;
    cache_hit_i = 1'b0; cache_data_i = '0; replace_way_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0; mem_data_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    #1;
    vectors++;
    if ({ldu_req_ready_o, ldu_valid_o, cache_read_o, cache_write_o, cache_validate_o, mem_req_o} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 100000", {ldu_req_ready_o, ldu_valid_o, cache_read_o, cache_write_o, cache_validate_o, mem_req_o});
    end
    vectors++;
    if (ldu_data_o !== 32'h0) begin
      miscompares++; $display("FAIL reset_data: got %h want 00000000", ldu_data_o);
    end
    step();
  endtask

  task automatic test_hit(input logic [31:0] addr, input logic [31:0] data);
    ldu_req_valid_i = 1'b1; ldu_address_i = addr;
    #1;
    vectors++;
    if (cache_read_o !== 1'b1 || cache_address_o !== addr) begin
      miscompares++; $display("FAIL hit_read: got rd=%b addr=%h want rd=1 addr=%h", cache_read_o, cache_address_o, addr);
    end
    step();
    ldu_req_valid_i = 1'b0; cache_hit_i = 1'b1; cache_data_i = data;
    #1;
    vectors++;
    if (ldu_req_ready_o !== 1'b0 || ldu_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL hit_compare: got rdy=%b vld=%b want rdy=0 vld=0", ldu_req_ready_o, ldu_valid_o);
    end
    step();
    cache_hit_i = 1'b0; cache_data_i = 32'h5555_5555;
    #1;
    vectors++;
    if (ldu_valid_o !== 1'b1 || ldu_data_o !== data || ldu_req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL hit_result: got vld=%b data=%h rdy=%b want vld=1 data=%h rdy=1", ldu_valid_o, ldu_data_o, ldu_req_ready_o, data);
    end
    step();
    vectors++;
    if (ldu_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL hit_pulse: got vld=%b want 0", ldu_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    ldu_req_valid_i = 1'b1; ldu_address_i = 32'h0000_5000;
    step();
    ldu_address_i = 32'h0000_5010; cache_hit_i = 1'b1; cache_data_i = 32'h1111_0001;
    #1;
    vectors++;
    if (cache_read_o !== 1'b0) begin
      miscompares++; $display("FAIL b2b_no_read_in_compare: got %b want 0", cache_read_o);
    end
    step();
    cache_hit_i = 1'b0;
    #1;
    vectors++;
    if (ldu_valid_o !== 1'b1 || ldu_data_o !== 32'h1111_0001 || cache_read_o !== 1'b1 || cache_address_o !== 32'h0000_5010) begin
      miscompares++;
      $display("FAIL b2b_first: got vld=%b data=%h rd=%b addr=%h want 1 11110001 1 00005010", ldu_valid_o, ldu_data_o, cache_read_o, cache_address_o);
    end
    step();
    ldu_req_valid_i = 1'b0; cache_hit_i = 1'b1; cache_data_i = 32'h2222_0002;
    step();
    cache_hit_i = 1'b0;
    #1;
    vectors++;
    if (ldu_valid_o !== 1'b1 || ldu_data_o !== 32'h2222_0002) begin
      miscompares++; $display("FAIL b2b_second: got vld=%b data=%h want 1 22220002", ldu_valid_o, ldu_data_o);
    end
    step();
  endtask

  // Full miss: spurious data in the first MISS_REQ cycle, gaps between words.
  task automatic test_miss(input logic [31:0] addr, input logic way, input int ack_delay,
                           input logic [31:0] base_word, input logic hold_req, input logic [31:0] exp_data);
    logic [31:0] line;
    line = addr & 32'hFFFF_FFF0;
    ldu_req_valid_i = 1'b1; ldu_address_i = addr;
    step();
    ldu_req_valid_i = hold_req; cache_hit_i = 1'b0; replace_way_i = way;
    #1;
    vectors++;
    if (cache_read_o !== 1'b0 || ldu_req_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL miss_compare: got rd=%b rdy=%b want 0 0", cache_read_o, ldu_req_ready_o);
    end
    step();
    replace_way_i = ~way;
    for (int k = 0; k <= ack_delay; k++) begin
      mem_ack_i = (k == ack_delay);
      mem_data_valid_i = (k == 0); mem_data_i = 32'hBAD0_0000;
      #1;
      vectors++;
      if (mem_req_o !== 1'b1 || mem_address_o !== line || cache_write_o !== 1'b0 || cache_read_o !== 1'b0) begin
        miscompares++;
        $display("FAIL miss_req[%0d]: got req=%b addr=%h wr=%b rd=%b want 1 %h 0 0", k, mem_req_o, mem_address_o, cache_write_o, cache_read_o, line);
      end
      step();
    end
    mem_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_data_valid_i = 1'b1; mem_data_i = base_word + i;
      #1;
      vectors++;
      if (cache_write_o !== 1'b1 || cache_write_way_o !== way || cache_write_address_o !== line + 32'(4 * i) ||
          cache_write_data_o !== base_word + i || cache_validate_o !== (i == 3) || mem_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL refill_word[%0d]: got wr=%b way=%b addr=%h data=%h val=%b req=%b want 1 %b %h %h %b 0",
                 i, cache_write_o, cache_write_way_o, cache_write_address_o, cache_write_data_o, cache_validate_o,
                 mem_req_o, way, line + 32'(4 * i), base_word + i, (i == 3));
      end
      step();
      if (i < 3) begin
        mem_data_valid_i = 1'b0;
        #1;
        vectors++;
        if (cache_write_o !== 1'b0 || cache_validate_o !== 1'b0 || ldu_valid_o !== 1'b0 || cache_read_o !== 1'b0) begin
          miscompares++;
          $display("FAIL refill_gap[%0d]: got wr=%b val=%b vld=%b rd=%b want 0 0 0 0", i, cache_write_o, cache_validate_o, ldu_valid_o, cache_read_o);
        end
        step();
      end
    end
    mem_data_valid_i = 1'b0;
    #1;
    vectors++;
    if (ldu_valid_o !== 1'b1 || ldu_data_o !== exp_data || ldu_req_ready_o !== 1'b1 || cache_read_o !== hold_req) begin
      miscompares++;
      $display("FAIL miss_result: got vld=%b data=%h rdy=%b rd=%b want 1 %h 1 %b", ldu_valid_o, ldu_data_o, ldu_req_ready_o, cache_read_o, exp_data, hold_req);
    end
    step();
    ldu_req_valid_i = 1'b0;
    if (hold_req) begin
      cache_hit_i = 1'b1; cache_data_i = 32'h7777_0007;
      step();
      cache_hit_i = 1'b0;
      #1;
      vectors++;
      if (ldu_valid_o !== 1'b1 || ldu_data_o !== 32'h7777_0007) begin
        miscompares++; $display("FAIL held_request: got vld=%b data=%h want 1 77770007", ldu_valid_o, ldu_data_o);
      end
      step();
    end
  endtask

  task automatic test_spurious_idle();
    for (int i = 0; i < 2; i++) begin
      mem_data_valid_i = 1'b1; mem_data_i = 32'hBAD0_1111;
      #1;
      vectors++;
      if (cache_write_o !== 1'b0 || cache_validate_o !== 1'b0 || ldu_valid_o !== 1'b0) begin
        miscompares++; $display("FAIL spurious_idle[%0d]: got wr=%b val=%b vld=%b want 0 0 0", i, cache_write_o, cache_validate_o, ldu_valid_o);
      end
      step();
    end
    mem_data_valid_i = 1'b0;
  endtask

  task automatic test_reset_during_refill();
    ldu_req_valid_i = 1'b1; ldu_address_i = 32'h0000_4004;
    step();
    ldu_req_valid_i = 1'b0; cache_hit_i = 1'b0; replace_way_i = 1'b1;
    step();
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_data_valid_i = 1'b1; mem_data_i = 32'hC0 + i;
      step();
    end
    mem_data_valid_i = 1'b0; rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    vectors++;
    if ({ldu_valid_o, cache_read_o, cache_write_o, cache_validate_o, mem_req_o} !== 5'b0 || ldu_data_o !== 32'h0 || ldu_req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_refill: got vld=%b rd=%b wr=%b val=%b req=%b data=%h rdy=%b want all 0, rdy=1",
               ldu_valid_o, cache_read_o, cache_write_o, cache_validate_o, mem_req_o, ldu_data_o, ldu_req_ready_o);
    end
    for (int i = 2; i < 4; i++) begin
      mem_data_valid_i = 1'b1; mem_data_i = 32'hC0 + i;
      #1;
      vectors++;
      if (cache_write_o !== 1'b0 || cache_validate_o !== 1'b0 || ldu_valid_o !== 1'b0) begin
        miscompares++; $display("FAIL abandoned_refill[%0d]: got wr=%b val=%b vld=%b want 0 0 0", i, cache_write_o, cache_validate_o, ldu_valid_o);
      end
      step();
    end
    mem_data_valid_i = 1'b0;
    test_hit(32'h0000_4008, 32'h0BAD_F00D);
  endtask

  initial begin
    test_reset();
    test_hit(32'h0000_1004, 32'hDEAD_BEEF);
    test_back_to_back();
    test_miss(32'h0000_2008, 1'b1, 3, 32'hA0, 1'b0, 32'hA2);
    test_spurious_idle();
    test_miss(32'h0000_6004, 1'b0, 1, 32'hB0, 1'b1, 32'hB1);
    test_reset_during_refill();
    test_miss(32'h0000_300C, 1'b1, 0, 32'hD0, 1'b0, 32'hD3);
    test_miss(32'h0000_7000, 1'b0, 2, 32'hE0, 1'b0, 32'hE0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
